// File: rtl/sevenseg_reader.sv
// Seven-segment bus reader: synchronizes disp/dig, waits for a stable slot and decodes it per position.
// Build option: define SEGRD_HEX_EN to accept the A..F glyphs as legal codes.
module sevenseg_reader #(
  parameter int STABLE_CYCLES  = 4,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  disp,
  input  logic [5:0]  dig,
  input  logic        err_clr,
  output logic [23:0] digits,
  output logic [5:0]  digit_valid,
  output logic [5:0]  seg_err,
  output logic        sel_err,
  output logic        update,
  output logic [2:0]  update_idx,
  output logic        frame_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_CAPTURE, ST_HOLD} state_t;

  // CAPTURE is entered on the edge where the counter would reach STABLE_CYCLES-1.
  localparam logic [7:0] LP_CAP_AT = 8'(STABLE_CYCLES - 2);

  logic [6:0]  w_disp_pol;
  logic [5:0]  w_dig_pol;
  logic [6:0]  r_disp_m, r_disp_s;
  logic [5:0]  r_dig_m, r_dig_s;
  logic [12:0] w_sample;
  logic [12:0] r_prev;
  logic [12:0] r_cap;
  logic [7:0]  r_cnt;
  logic        w_same;
  state_t      r_state, w_state_next;
  logic        w_capture, w_load_cap;
  logic [6:0]  w_cap_disp;
  logic [5:0]  w_cap_dig;
  logic [3:0]  w_code;
  logic        w_legal, w_blank, w_onehot;
  logic [2:0]  w_pos;
  logic [5:0]  w_seen_set, w_seg_set;
  logic        w_frame, w_take;
  logic [3:0]  r_digit [6];
  logic [5:0]  r_valid, r_seg_err, r_seen;
  logic        r_sel_err, r_update, r_frame_done;
  logic [2:0]  r_update_idx;

  assign w_disp_pol = (SEG_ACTIVE_LOW != 0) ? ~disp : disp;
  assign w_dig_pol  = (DIG_ACTIVE_LOW != 0) ? ~dig  : dig;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp_m <= '0;
      r_disp_s <= '0;
      r_dig_m  <= '0;
      r_dig_s  <= '0;
    end else begin
      r_disp_m <= w_disp_pol;
      r_disp_s <= r_disp_m;
      r_dig_m  <= w_dig_pol;
      r_dig_s  <= r_dig_m;
    end
  end

  assign w_sample = {r_dig_s, r_disp_s};
  assign w_same   = (w_sample == r_prev);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= '0;
      r_cnt  <= '0;
    end else begin
      r_prev <= w_sample;
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != 8'hFF)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_dig_s != '0)
          w_state_next = ST_TRACK;
      end
      ST_TRACK: begin
        if (r_dig_s == '0)
          w_state_next = ST_IDLE;
        else if (w_same && (r_cnt >= LP_CAP_AT))
          w_state_next = ST_CAPTURE;
      end
      ST_CAPTURE: w_state_next = ST_HOLD;
      ST_HOLD: begin
        // Compare against the captured slot so a change during CAPTURE is not missed.
        if (w_sample != r_cap)
          w_state_next = (r_dig_s == '0) ? ST_IDLE : ST_TRACK;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_capture  = (r_state == ST_CAPTURE);
    w_load_cap = (r_state == ST_TRACK) && (w_state_next == ST_CAPTURE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cap <= '0;
    else if (w_load_cap)
      r_cap <= w_sample;
  end

  assign w_cap_disp = r_cap[6:0];
  assign w_cap_dig  = r_cap[12:7];

  always_comb begin
    w_code  = 4'h0;
    w_legal = 1'b1;
    w_blank = (w_cap_disp == 7'h00);
    case (w_cap_disp)
      7'h3F: w_code = 4'h0;
      7'h06: w_code = 4'h1;
      7'h5B: w_code = 4'h2;
      7'h4F: w_code = 4'h3;
      7'h66: w_code = 4'h4;
      7'h6D: w_code = 4'h5;
      7'h7D: w_code = 4'h6;
      7'h07: w_code = 4'h7;
      7'h7F: w_code = 4'h8;
      7'h6F: w_code = 4'h9;
`ifdef SEGRD_HEX_EN
      7'h77: w_code = 4'hA;
      7'h7C: w_code = 4'hB;
      7'h39: w_code = 4'hC;
      7'h5E: w_code = 4'hD;
      7'h79: w_code = 4'hE;
      7'h71: w_code = 4'hF;
`endif
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_onehot = (w_cap_dig != '0) && ((w_cap_dig & (w_cap_dig - 6'd1)) == '0);
    w_pos    = 3'd0;
    for (int i = 0; i < 6; i++)
      if (w_cap_dig[i])
        w_pos = 3'(i);
  end

  assign w_take     = w_capture && w_onehot;
  assign w_seen_set = r_seen | w_cap_dig;
  assign w_frame    = w_take && (w_seen_set == 6'h3F);
  assign w_seg_set  = (w_take && !w_legal && !w_blank) ? w_cap_dig : 6'h00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++)
        r_digit[i] <= '0;
      r_valid      <= '0;
      r_seg_err    <= '0;
      r_sel_err    <= 1'b0;
      r_update     <= 1'b0;
      r_update_idx <= '0;
      r_frame_done <= 1'b0;
      r_seen       <= '0;
    end else begin
      r_update     <= w_take;
      r_frame_done <= w_frame;
      if (w_take) begin
        r_update_idx <= w_pos;
        r_seen       <= w_frame ? 6'h00 : w_seen_set;
      end
      for (int i = 0; i < 6; i++) begin
        if (w_take && w_cap_dig[i]) begin
          if (w_legal) begin
            r_digit[i] <= w_code;
            r_valid[i] <= 1'b1;
          end else begin
            r_valid[i] <= 1'b0;
          end
        end
      end
      // Clear first, then OR in new errors so a coincident set wins.
      r_seg_err <= (err_clr ? 6'h00 : r_seg_err) | w_seg_set;
      r_sel_err <= (r_sel_err & ~err_clr) | (w_capture && !w_onehot);
    end
  end

  for (genvar gi = 0; gi < 6; gi++) begin : g_digits
    assign digits[gi*4 +: 4] = r_digit[gi];
  end

  assign digit_valid = r_valid;
  assign seg_err     = r_seg_err;
  assign sel_err     = r_sel_err;
  assign update      = r_update;
  assign update_idx  = r_update_idx;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Directed bench for sevenseg_reader (default parameters); honours SEGRD_HEX_EN for the hex glyph case.
module tb_sevenseg_reader;
  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  disp;
  logic [5:0]  dig;
  logic        err_clr;
  logic [23:0] digits;
  logic [5:0]  digit_valid;
  logic [5:0]  seg_err;
  logic        sel_err;
  logic        update;
  logic [2:0]  update_idx;
  logic        frame_done;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic last_fd;
  logic [2:0] last_idx;
  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  sevenseg_reader dut (
    .clk(clk), .reset(reset), .disp(disp), .dig(dig), .err_clr(err_clr),
    .digits(digits), .digit_valid(digit_valid), .seg_err(seg_err), .sel_err(sel_err),
    .update(update), .update_idx(update_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [5:0] d, input logic [6:0] s);
    @(posedge clk); #1;
    dig  = d;
    disp = s;
  endtask

  task automatic wait_upd(output int n);
    n = -1;
    for (int i = 1; i <= 40 && n < 0; i++) begin
      @(posedge clk); #1;
      if (update) begin
        n        = i;
        last_fd  = frame_done;
        last_idx = update_idx;
      end
    end
    $display("txn dig=%b disp=%h latency=%0d idx=%0d digits=%h valid=%h seg_err=%h fd=%b",
             dig, disp, n, update_idx, digits, digit_valid, seg_err, frame_done);
  endtask

  task automatic count_upd(input int cyc, output int cnt);
    cnt = 0;
    repeat (cyc) begin
      @(posedge clk); #1;
      if (update) cnt++;
    end
    $display("txn dig=%b disp=%h window=%0d updates=%0d sel_err=%b", dig, disp, cyc, cnt, sel_err);
  endtask

  task automatic pulse_clr();
    @(posedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    reset = 1'b1; dig = '0; disp = '0; err_clr = 1'b0;
    last_fd = 1'b0; last_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", 32'(digits), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_flags", 32'({seg_err, sel_err, update, update_idx, frame_done}), 32'h0);
    reset = 1'b0;

    // Single held slot: latency 2 + 4 + 1
    apply(6'b000001, 7'h4F);
    wait_upd(n);
    chk("t1_latency", 32'(n), 32'd7);
    chk("t1_idx", 32'(last_idx), 32'd0);
    chk("t1_digit0", 32'(digits[3:0]), 32'h3);
    chk("t1_valid0", 32'(digit_valid[0]), 32'h1);
    count_upd(12, cnt);
    chk("t1_no_reupdate", 32'(cnt), 32'd0);

    // Scan positions 0..5 with codes 1..6
    for (int i = 0; i < 6; i++) begin
      apply(6'(1 << i), seg_tab[i+1]);
      wait_upd(n);
      chk($sformatf("scan%0d_latency", i), 32'(n), 32'd7);
      chk($sformatf("scan%0d_idx", i), 32'(last_idx), 32'(i));
      chk($sformatf("scan%0d_fd", i), 32'(last_fd), (i == 5) ? 32'd1 : 32'd0);
    end
    chk("scan_digits", 32'(digits), 32'h654321);
    chk("scan_valid", 32'(digit_valid), 32'h3F);
    chk("scan_seg_err", 32'(seg_err), 32'h0);

    // Bouncing segments never settle long enough
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      int c;
      apply(6'b000100, (i % 2 == 0) ? 7'h06 : 7'h5B);
      count_upd(1, c);
      cnt += c;
    end
    chk("t3_bounce_no_update", 32'(cnt), 32'd0);
    apply(6'b000100, 7'h5B);
    wait_upd(n);
    chk("t3_latency", 32'(n), 32'd7);
    chk("t3_digit2", 32'(digits[11:8]), 32'h2);
    count_upd(10, cnt);
    chk("t3_single", 32'(cnt), 32'd0);

    // 'A' glyph at position 1
    apply(6'b000010, 7'h77);
    wait_upd(n);
    chk("t4_latency", 32'(n), 32'd7);
`ifdef SEGRD_HEX_EN
    chk("t4_digits", 32'(digits), 32'h6542A1);
    chk("t4_valid", 32'(digit_valid), 32'h3F);
    chk("t4_seg_err", 32'(seg_err), 32'h00);
`else
    chk("t4_digits", 32'(digits), 32'h654221);
    chk("t4_valid", 32'(digit_valid), 32'h3D);
    chk("t4_seg_err", 32'(seg_err), 32'h02);
`endif
    pulse_clr();
    chk("t4_seg_err_clr", 32'(seg_err), 32'h00);

    // Multi-hot select
    apply(6'b000011, 7'h06);
    count_upd(12, cnt);
    chk("t5_mh_no_update", 32'(cnt), 32'd0);
    chk("t5_sel_err", 32'(sel_err), 32'd1);
    pulse_clr();
    chk("t5_sel_err_clr", 32'(sel_err), 32'd0);

    // Blank at position 0
    apply(6'b000001, 7'h00);
    wait_upd(n);
    chk("t5_blank_latency", 32'(n), 32'd7);
    chk("t5_blank_valid0", 32'(digit_valid[0]), 32'd0);
    chk("t5_blank_digit0", 32'(digits[3:0]), 32'h1);
    chk("t5_blank_seg_err", 32'(seg_err), 32'h00);

    // Seen so far: 0,1,2. Multi-hot on 3,4 must not count toward the frame.
    apply(6'b011000, 7'h06);
    count_upd(12, cnt);
    chk("t5_mh2_no_update", 32'(cnt), 32'd0);
    chk("t5_mh2_sel_err", 32'(sel_err), 32'd1);
    apply(6'b100000, seg_tab[5]);
    wait_upd(n);
    chk("t5_pos5_fd", 32'(last_fd), 32'd0);
    apply(6'b001000, seg_tab[3]);
    wait_upd(n);
    chk("t5_pos3_fd", 32'(last_fd), 32'd0);
    apply(6'b010000, seg_tab[4]);
    wait_upd(n);
    chk("t5_pos4_fd", 32'(last_fd), 32'd1);
    chk("t5_digits_hi", 32'(digits[23:12]), 32'h543);

    // Reset mid-TRACK
    apply(6'b000001, 7'h66);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_rst_digits", 32'(digits), 32'h0);
    chk("t6_rst_valid", 32'(digit_valid), 32'h0);
    chk("t6_rst_flags", 32'({seg_err, sel_err, update, update_idx, frame_done}), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    wait_upd(n);
    chk("t6_latency", 32'(n), 32'd7);
    chk("t6_digits", 32'(digits), 32'h000004);
    chk("t6_valid", 32'(digit_valid), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
